pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side conditioning block: converts single-cycle internal event strobes into a clean, human-visible pulse train on a physical output line (LED, buzzer, test pin). It is the dual of input debouncing. Each accepted event drives the line high for a fixed hold time, then forces a fixed low gap, so that back-to-back events stay distinguishable. Events that arrive while a pulse is in progress are queued in a saturating pending counter. The block sits between control logic and the board output pins.

## Interface
- HOLD_CYCLES, 100_000: high time of each output pulse in clock cycles; legal range 1 to 2^24-1.
- GAP_CYCLES, 100_000: forced low time after each pulse in clock cycles; legal range 1 to 2^24-1.
- PEND_WIDTH, 3: width of the pending-event counter; maximum queued events is 2^PEND_WIDTH-1.
- clock  input  1  system clock; all logic is on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- eventIn  input  1  event strobe; every cycle it is high counts as one event.
- lineOut  output  1  registered pulse output to the pin.
- busy  output  1  high while a pulse or gap is in progress, or while events are pending.
- pendingCount  output  PEND_WIDTH  number of queued events not yet emitted.
- dropCount  output  8  saturating count of discarded events; exists only with the configuration macro.

## Operation
- State machine has three states: IDLE, HIGH and GAP. A single 24-bit down-counter `cnt` is shared by HIGH and GAP.
- IDLE: lineOut=0.
  - If eventIn=1, go to HIGH with cnt=HOLD_CYCLES-1; pendingCount is unchanged.
- HIGH: lineOut=1.
  - While cnt!=0, decrement cnt.
  - When cnt==0, go to GAP with cnt=GAP_CYCLES-1.
- GAP: lineOut=0.
  - While cnt!=0, decrement cnt.
  - When cnt==0 and pendingCount>0, go directly to HIGH with cnt=HOLD_CYCLES-1 and decrement pendingCount.
  - When cnt==0 and pendingCount==0, go to IDLE.
- In HIGH or GAP, eventIn=1 increments pendingCount.
- Simultaneous event and pending consume (the GAP→HIGH edge): pendingCount is unchanged.
- Saturation: with pendingCount at 2^PEND_WIDTH-1 and no consume that cycle, the event is discarded and dropCount increments.
- busy = (state!=IDLE) | (pendingCount!=0). It is decoded combinationally from registers.
- Reset: asserting resetN forces, without a clock edge:
  - state=IDLE, cnt=0, lineOut=0, pendingCount=0, dropCount=0;
  - busy is then 0.
- Releasing reset mid-operation resumes from IDLE. No partial pulse is re-emitted.

## Timing
- Latency: an event sampled on edge N in IDLE gives lineOut=1 from cycle N+1.
- Each pulse is exactly HOLD_CYCLES high, followed by exactly GAP_CYCLES low.
- Pulse period for a queued stream is HOLD_CYCLES+GAP_CYCLES. There are no idle cycles between the end of a gap and the next pulse.
- pendingCount and dropCount update on the edge that samples the event, so they are visible one cycle later.
- lineOut is glitch-free: it is driven straight from a flop with no combinational path from eventIn.

## Configuration
- STRETCHER_DROP_CNT_EN defined:
  - the dropCount port and its 8-bit register exist;
  - the register increments by 1 per discarded event and saturates at 255;
  - it is cleared only by reset.
- Not defined:
  - the dropCount port and register are absent;
  - discarded events are silently lost;
  - all other behaviour is identical.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=3, PEND_WIDTH=2 and the macro defined. An event "in cycle N" is sampled on edge N.
- Single event in cycle 10 → lineOut=1 in cycles 11–14 and 0 from cycle 15; busy=1 in cycles 11–17, 0 at 18; pendingCount stays 0.
- Events in cycles 10 and 11 → pulses in cycles 11–14 and 18–21; pendingCount=1 in cycles 12–17, 0 from 18; busy drops at cycle 25.
- eventIn held high in cycles 10–15 →
  - pendingCount reaches 3 by cycle 14;
  - dropCount=2 from cycle 16;
  - exactly 4 pulses, starting at cycles 11, 18, 25 and 32.
- One queued event, plus a new event in cycle 17 (the GAP→HIGH edge) → pendingCount stays 1 across the transition, and a third pulse starts at cycle 25.
- resetN driven low asynchronously in the middle of cycle 12 during a pulse → lineOut, busy and pendingCount go to 0 immediately. After release, with no events, lineOut stays 0.
- Macro undefined, same saturation stimulus → still 4 pulses, and no dropCount port in elaboration.

Source files
------------

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle event strobes into a pulse train that a person can see
// or hear on a board pin. Every accepted event drives lineOut high for
// HOLD_CYCLES and then holds it low for GAP_CYCLES. Events that arrive while
// a pulse or gap is running are queued in a saturating pending counter and
// emitted back to back, one per HOLD_CYCLES+GAP_CYCLES period.
//
// Parameters
//   HOLD_CYCLES  high time per pulse in clocks (1 .. 2^24-1)
//   GAP_CYCLES   forced low time after each pulse in clocks (1 .. 2^24-1)
//   PEND_WIDTH   width of the pending counter; up to 2^PEND_WIDTH-1 queued
//
// Ports
//   clock         system clock, rising edge
//   resetN        asynchronous active-low reset
//   eventIn       event strobe; each high cycle is one event
//   lineOut       registered pulse output to the pin
//   busy          pulse or gap in progress, or events pending
//   pendingCount  queued events not yet emitted
//   dropCount     saturating count of discarded events (only when the macro
//                 STRETCHER_DROP_CNT_EN is defined)
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 100_000,
  parameter int GAP_CYCLES  = 100_000,
  parameter int PEND_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  eventIn,
  output logic                  lineOut,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pendingCount
`ifdef STRETCHER_DROP_CNT_EN
  ,
  output logic [7:0]            dropCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stateE;

  localparam logic [23:0]           HOLD_LOAD = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0]           GAP_LOAD  = 24'(GAP_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = {PEND_WIDTH{1'b1}};
  localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);

  stateE                 state;
  stateE                 stateNext;
  logic [23:0]           cnt;
  logic [23:0]           cntNext;
  logic [PEND_WIDTH-1:0] pendNext;
  logic                  consume;   // GAP finished with work queued: start next pulse
  logic                  accept;    // event arriving while a pulse/gap is running

  // ---------------------------------------------------------------------------
  // Next-state, counter reload and pending bookkeeping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    stateNext = state;
    cntNext   = cnt;
    consume   = 1'b0;

    unique case (state)
      IDLE: begin
        if (eventIn) begin
          stateNext = HIGH;
          cntNext   = HOLD_LOAD;
        end
      end
      HIGH: begin
        if (cnt != 24'd0) begin
          cntNext = cnt - 24'd1;
        end else begin
          stateNext = GAP;
          cntNext   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt != 24'd0) begin
          cntNext = cnt - 24'd1;
        end else if (pendingCount != '0) begin
          // Straight into the next pulse: no idle cycle between gap and pulse.
          stateNext = HIGH;
          cntNext   = HOLD_LOAD;
          consume   = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    // An event in IDLE starts the pulse itself and is never queued.
    accept   = eventIn && (state != IDLE);
    pendNext = pendingCount;
    if (accept && !consume) begin
      // At the ceiling the event is lost (and counted when drop counting exists).
      if (pendingCount != PEND_MAX) begin
        pendNext = pendingCount + PEND_ONE;
      end
    end else if (consume && !accept) begin
      pendNext = pendingCount - PEND_ONE;
    end
    // accept && consume: one event in, one event out, the count stays put.
  end

  // ---------------------------------------------------------------------------
  // State registers. lineOut comes straight from a flop loaded with the
  // decoded next state, so the pin never sees a combinational path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      cnt          <= '0;
      pendingCount <= '0;
      lineOut      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state        <= stateNext;
      cnt          <= cntNext;
      pendingCount <= pendNext;
      lineOut      <= (stateNext == HIGH);
    end
  end

  assign busy = (state != IDLE) || (pendingCount != '0);

`ifdef STRETCHER_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Discarded-event counter, saturating at 255, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic dropNow;

  always_comb begin
    dropNow = accept && !consume && (pendingCount == PEND_MAX);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dropCount <= 8'd0;
    end else if (dropNow && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed scenarios followed by a randomized run. Every cycle the DUT is
// compared against a reference model that tracks each pulse by its start
// cycle and derives the line/busy/pending/drop values from elapsed time.
// Cycle numbering: an event "in cycle N" is driven during cycle N and sampled
// on the edge that ends it; the values observed after that edge belong to
// cycle N+1.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clock;
  logic          resetN;
  logic          eventIn;
  logic          lineOut;
  logic          busy;
  logic [PW-1:0] pendingCount;
`ifdef STRETCHER_DROP_CNT_EN
  logic [7:0]    dropCount;
`endif

  pulse_stretcher #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PEND_WIDTH (PW)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .eventIn     (eventIn),
    .lineOut     (lineOut),
    .busy        (busy),
    .pendingCount(pendingCount)
`ifdef STRETCHER_DROP_CNT_EN
    ,
    .dropCount   (dropCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: pulse activity is described by the cycle the current
  // pulse started in; high for HOLD cycles from there, then GAP low cycles.
  bit mActive;
  int mStart;
  int mPend;
  int mDrop;

  int   cyc;
  logic lineLog [0:63];
  logic busyLog [0:63];
  int   pendLog [0:63];
  int   dropLog [0:63];
  int   starts[$];
  logic prevLine;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mActive = 1'b0;
    mStart  = 0;
    mPend   = 0;
    mDrop   = 0;
  endtask

  // Apply the behavioural rules for the edge that ends cycle c.
  task automatic modelStep(input logic ev, input int c);
    bit wasActive = mActive;
    bit endGap    = mActive && ((c - mStart) == HOLD + GAP - 1);
    bit takeNext  = endGap && (mPend > 0);
    if (ev && wasActive && !takeNext) begin
      if (mPend == PMAX) begin
        if (mDrop < 255) mDrop++;
      end else begin
        mPend++;
      end
    end
    if (takeNext && !ev) mPend--;
    if (!wasActive && ev) begin
      mActive = 1'b1;
      mStart  = c + 1;
    end else if (takeNext) begin
      mStart = c + 1;
    end else if (endGap) begin
      mActive = 1'b0;
    end
  endtask

  task automatic doReset();
    eventIn = 1'b0;
    resetN  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    modelReset();
    cyc      = 0;
    prevLine = 1'b0;
    starts.delete();
    for (int i = 0; i < 64; i++) begin
      lineLog[i] = 1'b0;
      busyLog[i] = 1'b0;
      pendLog[i] = 0;
      dropLog[i] = 0;
    end
  endtask

  // One clock: drive the event for cycle cyc, then compare cycle cyc+1.
  task automatic tick(input logic ev);
    logic expLine;
    logic expBusy;
    @(negedge clock);
    eventIn = ev;
    @(posedge clock);
    modelStep(ev, cyc);
    cyc++;
    #1;
    expLine = mActive && ((cyc - mStart) < HOLD);
    expBusy = mActive || (mPend != 0);
    check($sformatf("line@%0d", cyc), 32'(lineOut), 32'(expLine));
    check($sformatf("busy@%0d", cyc), 32'(busy), 32'(expBusy));
    check($sformatf("pend@%0d", cyc), 32'(pendingCount), 32'(mPend));
`ifdef STRETCHER_DROP_CNT_EN
    check($sformatf("drop@%0d", cyc), 32'(dropCount), 32'(mDrop));
`endif
    if (cyc < 64) begin
      lineLog[cyc] = lineOut;
      busyLog[cyc] = busy;
      pendLog[cyc] = int'(pendingCount);
`ifdef STRETCHER_DROP_CNT_EN
      dropLog[cyc] = int'(dropCount);
`endif
    end
    if (lineOut && !prevLine) starts.push_back(cyc);
    prevLine = lineOut;
  endtask

  task automatic runMask(input int nCycles, input logic [63:0] mask);
    for (int c = 0; c < nCycles; c++) tick(mask[c]);
    eventIn = 1'b0;
  endtask

  initial begin
    logic [63:0] mask;
    logic        burst;
    logic        ev;

    // ---- reset state ----
    doReset();
    #1;
    check("reset_line", 32'(lineOut), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pend", 32'(pendingCount), 32'd0);
`ifdef STRETCHER_DROP_CNT_EN
    check("reset_drop", 32'(dropCount), 32'd0);
`endif

    // ---- single event in cycle 10 ----
    doReset();
    mask = '0;
    mask[10] = 1'b1;
    runMask(30, mask);
    check("s1_line10", 32'(lineLog[10]), 32'd0);
    check("s1_line11", 32'(lineLog[11]), 32'd1);
    check("s1_line14", 32'(lineLog[14]), 32'd1);
    check("s1_line15", 32'(lineLog[15]), 32'd0);
    check("s1_busy17", 32'(busyLog[17]), 32'd1);
    check("s1_busy18", 32'(busyLog[18]), 32'd0);
    check("s1_pend12", 32'(pendLog[12]), 32'd0);
    check("s1_npulse", 32'(starts.size()), 32'd1);

    // ---- events in cycles 10 and 11 ----
    doReset();
    mask = '0;
    mask[10] = 1'b1;
    mask[11] = 1'b1;
    runMask(35, mask);
    check("s2_npulse", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) begin
      check("s2_start0", 32'(starts[0]), 32'd11);
      check("s2_start1", 32'(starts[1]), 32'd18);
    end
    check("s2_line21", 32'(lineLog[21]), 32'd1);
    check("s2_line22", 32'(lineLog[22]), 32'd0);
    check("s2_pend12", 32'(pendLog[12]), 32'd1);
    check("s2_pend17", 32'(pendLog[17]), 32'd1);
    check("s2_pend18", 32'(pendLog[18]), 32'd0);
    check("s2_busy24", 32'(busyLog[24]), 32'd1);
    check("s2_busy25", 32'(busyLog[25]), 32'd0);

    // ---- eventIn held high in cycles 10..15: saturation ----
    doReset();
    mask = '0;
    for (int i = 10; i <= 15; i++) mask[i] = 1'b1;
    runMask(50, mask);
    check("s3_pend13", 32'(pendLog[13]), 32'd2);
    check("s3_pend14", 32'(pendLog[14]), 32'd3);
`ifdef STRETCHER_DROP_CNT_EN
    check("s3_drop15", 32'(dropLog[15]), 32'd1);
    check("s3_drop16", 32'(dropLog[16]), 32'd2);
`endif
    check("s3_npulse", 32'(starts.size()), 32'd4);
    if (starts.size() == 4) begin
      check("s3_start0", 32'(starts[0]), 32'd11);
      check("s3_start1", 32'(starts[1]), 32'd18);
      check("s3_start2", 32'(starts[2]), 32'd25);
      check("s3_start3", 32'(starts[3]), 32'd32);
    end

    // ---- one queued event plus an event on the GAP->HIGH edge ----
    doReset();
    mask = '0;
    mask[10] = 1'b1;
    mask[11] = 1'b1;
    mask[17] = 1'b1;
    runMask(45, mask);
    check("s4_pend17", 32'(pendLog[17]), 32'd1);
    check("s4_pend18", 32'(pendLog[18]), 32'd1);
    check("s4_pend25", 32'(pendLog[25]), 32'd0);
    check("s4_npulse", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      check("s4_start2", 32'(starts[2]), 32'd25);
    end

    // ---- asynchronous reset in the middle of cycle 12 ----
    doReset();
    mask = '0;
    mask[10] = 1'b1;
    mask[11] = 1'b1;
    runMask(12, mask);
    check("s5_line_pre", 32'(lineOut), 32'd1);
    check("s5_pend_pre", 32'(pendingCount), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check("s5_line_rst", 32'(lineOut), 32'd0);
    check("s5_busy_rst", 32'(busy), 32'd0);
    check("s5_pend_rst", 32'(pendingCount), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    modelReset();
    cyc = 0;
    prevLine = 1'b0;
    starts.delete();
    runMask(15, '0);
    check("s5_line_after", 32'(lineOut), 32'd0);
    check("s5_npulse", 32'(starts.size()), 32'd0);

    // ---- randomized traffic: sparse events with occasional bursts ----
    doReset();
    burst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) burst = ~burst;
      if (burst) ev = ($urandom_range(0, 1) == 1);
      else       ev = ($urandom_range(0, 11) == 0);
      tick(ev);
    end
    runMask(40, '0);
    check("rnd_drain_busy", 32'(busy), 32'(mActive || (mPend != 0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
